rp_8bit_bd_arb: RTL and testbench
=================================

Name: rp_8bit_bd_arb

Overview:
- Two-port arbiter sharing the single-port synchronous data memory behind the rp_8bit data bus.
- Port 0 is the core data bus (bd_*). Port 1 is a DMA/debug master.
- Issues at most one access per cycle to the memory. Routes 1-cycle-latency read data back to the issuing port and holds it there.
- Round-robin or fixed-priority arbitration, with a port-1 lock and port-1 starvation guard.

Parameters:
- DAW, 13, data address width.
- DW, 8, data width.
- RRB, 1, 1 = round-robin, 0 = fixed priority to port 0.
- STV, 8, fixed mode only: port-1 wait cycles before a forced grant; 0 disables the guard.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- p0_req  in  1  port 0 request, held until ack
- p0_wen  in  1  port 0 write enable
- p0_adr  in  DAW  port 0 address
- p0_wdt  in  DW  port 0 write data
- p0_rdt  out  DW  port 0 read data
- p0_ack  out  1  port 0 access issued this cycle
- p1_req, p1_wen, p1_adr, p1_wdt, p1_rdt, p1_ack  same as port 0, for port 1
- p1_lck  in  1  port 1 lock: keep grant across back-to-back accesses
- mem_ena  out  1  memory enable
- mem_wen  out  1  memory write enable
- mem_adr  out  DAW  memory address
- mem_wdt  out  DW  memory write data
- mem_rdt  in  DW  memory read data, valid 1 cycle after a read is issued

Behaviour:
- State registers:
  - lst: last granted port, reset 1, so port 0 wins the first contest.
  - lkd: port 1 holds lock, reset 0.
  - wcnt: port-1 wait count, width clog2(STV+1), reset 0.
  - rd_vld/rd_prt: outstanding read, reset 0/0.
  - h0/h1: read-data holds, reset 0.
- Grant is combinational from the requests and state in cycle t:
  - Only one request asserted: that port wins.
  - Both asserted, priority order:
    - lkd=1: port 1 wins.
    - RRB=0, STV>0 and wcnt==STV: port 1 wins.
    - RRB=1: the port != lst wins.
    - RRB=0: port 0 wins.
- Winner W in cycle t:
  - mem_ena=1; mem_wen/mem_adr/mem_wdt = pW_wen/pW_adr/pW_wdt.
  - pW_ack=1; the loser's ack is 0.
  - Ack means the access is accepted. The requester may change or drop req on the next cycle.
- Idle cycle (no request): mem_ena=0, mem_wen=0, mem_adr=0, mem_wdt=0, both acks 0.
- Clock edge after cycle t:
  - lst <= W if any grant.
  - lkd <= (W==1) & p1_lck.
  - lkd also clears when p1_req=0 or p1_lck=0 in a cycle.
  - wcnt <= 0 if port 1 is granted or p1_req=0; otherwise wcnt+1, saturating at STV.
  - rd_vld <= grant & !pW_wen; rd_prt <= W.
- Read return:
  - pX_rdt = mem_rdt when rd_vld & rd_prt==X; otherwise hX. This is combinational, so data appears in cycle t+1.
  - hX <= mem_rdt at the edge ending that t+1 cycle.
  - pX_rdt then stays stable until the next read completes for port X. Writes and the other port's reads do not disturb it.
- Write latency: the write completes at the edge ending cycle t. A read of the same address issued at t+1 returns the new data.
- Back-to-back accesses:
  - Full throughput: one access per cycle.
  - A read at t and any access at t+1 are legal; the return path at t+1 is independent of the new issue.
- Fairness:
  - RRB=1 with both ports requesting continuously: grants alternate 0,1,0,1.
  - A lock overrides alternation until released.
- Reset, asynchronous and active-high, at any point including mid-access:
  - All state goes to its reset value; an outstanding read is discarded.
  - p0_rdt=p1_rdt=0; acks and mem_ena follow the requests combinationally, with lst=1.
- Simultaneous lock and starvation force both select port 1; no conflict.
- Lock asserted while port 1 has no grant has no effect until port 1 wins.
- Requester protocol violation (req dropped before ack) is legal and simply withdraws the request.

Test Plan:
- Reset, then p0 read of adr 0x010 (memory preloaded 0x5A) -> p0_ack at t, p0_rdt=0x5A at t+1 and held; p1_rdt stays 0x00.
- RRB=1, both ports request continuously for 6 cycles (p0 writes, p1 reads) -> acks alternate p0,p1,p0,p1,p0,p1; mem_adr alternates accordingly.
- p1 write 0x33 to 0x100 at t, then p0 read of 0x100 at t+1 -> p0_rdt=0x33 at t+2.
- RRB=0, STV=8, p0 requests every cycle and p1 waits -> p1 is granted exactly on its 9th waiting cycle, then wcnt returns to 0.
- p1_lck=1 with 4 p1 reads back-to-back while p0 requests -> 4 consecutive p1 acks, then p0 is granted the cycle after p1_lck drops.
- rst asserted the cycle after a p0 read issue -> p0_rdt=0x00 immediately, the read data is never delivered, and the first post-reset contest goes to p0.

Source files
------------

// File: rtl/rp_8bit_bd_arb_if.sv
// Bus bundle for the rp_8bit data-memory arbiter: two requester ports plus the
// single-port memory side. The arbiter takes the slave view, requesters the master view.
interface rp_8bit_bd_arb_if #(
   parameter int DAW = 13,
   parameter int DW  = 8
);
   // Port 0: core data bus
   logic           p0_req;
   logic           p0_wen;
   logic [DAW-1:0] p0_adr;
   logic [DW-1:0]  p0_wdt;
   logic [DW-1:0]  p0_rdt;
   logic           p0_ack;

   // Port 1: DMA / debug master
   logic           p1_req;
   logic           p1_wen;
   logic [DAW-1:0] p1_adr;
   logic [DW-1:0]  p1_wdt;
   logic [DW-1:0]  p1_rdt;
   logic           p1_ack;
   logic           p1_lck;

   // Shared single-port synchronous memory
   logic           mem_ena;
   logic           mem_wen;
   logic [DAW-1:0] mem_adr;
   logic [DW-1:0]  mem_wdt;
   logic [DW-1:0]  mem_rdt;

   // Handshake: a port raises req with wen/adr/wdt stable and holds them until
   // it sees ack in the same cycle; ack means the access was issued to memory
   // that cycle. Read data appears on rdt the following cycle and is held.
   modport slave (
      input  p0_req, p0_wen, p0_adr, p0_wdt,
      output p0_rdt, p0_ack,
      input  p1_req, p1_wen, p1_adr, p1_wdt, p1_lck,
      output p1_rdt, p1_ack,
      output mem_ena, mem_wen, mem_adr, mem_wdt,
      input  mem_rdt
   );

   modport master (
      output p0_req, p0_wen, p0_adr, p0_wdt,
      input  p0_rdt, p0_ack,
      output p1_req, p1_wen, p1_adr, p1_wdt, p1_lck,
      input  p1_rdt, p1_ack,
      input  mem_ena, mem_wen, mem_adr, mem_wdt,
      output mem_rdt
   );
endinterface

// File: rtl/rp_8bit_bd_arb.sv
// Two-port arbiter in front of the rp_8bit single-port data memory: one access
// per cycle, round-robin or fixed priority, port-1 lock and starvation guard.
module rp_8bit_bd_arb #(
   parameter int DAW = 13,
   parameter int DW  = 8,
   parameter int RRB = 1,
   parameter int STV = 8
) (
   input  logic             clk,
   input  logic             rst,
   rp_8bit_bd_arb_if.slave  bus
);
   localparam int            WCW  = (STV > 0) ? $clog2(STV + 1) : 1;
   localparam logic [WCW-1:0] WMAX = WCW'(STV);

   logic           lst_q, lst_d;
   logic           lkd_q, lkd_d;
   logic [WCW-1:0] wcnt_q, wcnt_d;
   logic           rd_vld_q, rd_vld_d;
   logic           rd_prt_q, rd_prt_d;
   logic [DW-1:0]  h0_q, h0_d;
   logic [DW-1:0]  h1_q, h1_d;

   logic           gnt;
   logic           gnt_prt;
   logic           starve;
   logic           sel_wen;
   logic [DAW-1:0] sel_adr;
   logic [DW-1:0]  sel_wdt;
   logic           ret0;
   logic           ret1;

   // Winner selection; lock and starvation both point at port 1 so they never conflict
   always_comb begin
      starve  = (RRB == 0) && (STV > 0) && (wcnt_q == WMAX);
      gnt     = bus.p0_req | bus.p1_req;
      gnt_prt = 1'b0;
      if (bus.p0_req && bus.p1_req) begin
         if (lkd_q)
            gnt_prt = 1'b1;
         else if (starve)
            gnt_prt = 1'b1;
         else if (RRB != 0)
            gnt_prt = ~lst_q;
         else
            gnt_prt = 1'b0;
      end else if (bus.p1_req) begin
         gnt_prt = 1'b1;
      end
   end

   always_comb begin
      sel_wen = 1'b0;
      sel_adr = '0;
      sel_wdt = '0;
      if (gnt) begin
         sel_wen = gnt_prt ? bus.p1_wen : bus.p0_wen;
         sel_adr = gnt_prt ? bus.p1_adr : bus.p0_adr;
         sel_wdt = gnt_prt ? bus.p1_wdt : bus.p0_wdt;
      end
   end

   assign bus.mem_ena = gnt;
   assign bus.mem_wen = sel_wen;
   assign bus.mem_adr = sel_adr;
   assign bus.mem_wdt = sel_wdt;
   assign bus.p0_ack  = gnt & ~gnt_prt;
   assign bus.p1_ack  = gnt & gnt_prt;

   // Read return is steered combinationally in the cycle after issue, then held
   assign ret0       = rd_vld_q & ~rd_prt_q;
   assign ret1       = rd_vld_q & rd_prt_q;
   assign bus.p0_rdt = ret0 ? bus.mem_rdt : h0_q;
   assign bus.p1_rdt = ret1 ? bus.mem_rdt : h1_q;

   always_comb begin
      lst_d    = gnt ? gnt_prt : lst_q;
      lkd_d    = gnt & gnt_prt & bus.p1_lck & bus.p1_req;
      rd_vld_d = gnt & ~sel_wen;
      rd_prt_d = gnt_prt;
      h0_d     = ret0 ? bus.mem_rdt : h0_q;
      h1_d     = ret1 ? bus.mem_rdt : h1_q;
      if (!bus.p1_req || (gnt && gnt_prt))
         wcnt_d = '0;
      else if (wcnt_q == WMAX)
         wcnt_d = WMAX;
      else
         wcnt_d = wcnt_q + WCW'(1);
   end

   // lst resets to 1 so port 0 takes the first round-robin contest
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         lst_q    <= 1'b1;
         lkd_q    <= 1'b0;
         wcnt_q   <= '0;
         rd_vld_q <= 1'b0;
         rd_prt_q <= 1'b0;
         h0_q     <= '0;
         h1_q     <= '0;
      end else begin
         lst_q    <= lst_d;
         lkd_q    <= lkd_d;
         wcnt_q   <= wcnt_d;
         rd_vld_q <= rd_vld_d;
         rd_prt_q <= rd_prt_d;
         h0_q     <= h0_d;
         h1_q     <= h1_d;
      end
   end
endmodule

// File: tb/tb_rp_8bit_bd_arb.sv
// Bench for rp_8bit_bd_arb: a round-robin and a fixed-priority instance, each with
// its own memory, checked every cycle against a transaction-level model.
module tb_rp_8bit_bd_arb;
   localparam int DAW = 13;
   localparam int DW  = 8;
   localparam int STV = 8;
   localparam int MSZ = 2 ** DAW;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   logic           preload_en  = 1'b0;
   logic [DAW-1:0] preload_adr = '0;
   logic [DW-1:0]  preload_dat = '0;

   rp_8bit_bd_arb_if #(.DAW(DAW), .DW(DW)) bus_rr ();
   rp_8bit_bd_arb_if #(.DAW(DAW), .DW(DW)) bus_fp ();

   rp_8bit_bd_arb #(.DAW(DAW), .DW(DW), .RRB(1), .STV(STV)) u_rr (
      .clk(clk), .rst(rst), .bus(bus_rr.slave));
   rp_8bit_bd_arb #(.DAW(DAW), .DW(DW), .RRB(0), .STV(STV)) u_fp (
      .clk(clk), .rst(rst), .bus(bus_fp.slave));

   // Behavioural single-port synchronous memories
   bit [DW-1:0] mem_rr [MSZ];
   bit [DW-1:0] mem_fp [MSZ];

   always @(posedge clk) begin
      if (preload_en) begin
         mem_rr[preload_adr] <= preload_dat;
         mem_fp[preload_adr] <= preload_dat;
      end else begin
         if (bus_rr.mem_ena) begin
            if (bus_rr.mem_wen) mem_rr[bus_rr.mem_adr] <= bus_rr.mem_wdt;
            else                bus_rr.mem_rdt <= mem_rr[bus_rr.mem_adr];
         end
         if (bus_fp.mem_ena) begin
            if (bus_fp.mem_wen) mem_fp[bus_fp.mem_adr] <= bus_fp.mem_wdt;
            else                bus_fp.mem_rdt <= mem_fp[bus_fp.mem_adr];
         end
      end
   end

   task automatic chk(input string nm, input int d, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s dut%0d: got %0h expected %0h at %0t", nm, d, act, exp, $time);
      end
   endtask

   // ---------------- transaction-level model ----------------
   bit          m_last [2] = '{1'b1, 1'b1};
   bit          m_lock [2];
   int          m_wait [2];
   bit          m_pv   [2];
   int          m_pp   [2];
   bit [DW-1:0] m_pd   [2];
   bit [DW-1:0] m_hold [2][2];
   bit [DW-1:0] ref_mem [2][MSZ];

   function automatic int pick(bit r0, bit r1, bit lk, bit starve, bit last, bit rrb);
      if (!r0 && !r1) return -1;
      if (!r1) return 0;
      if (!r0) return 1;
      if (lk) return 1;
      if (!rrb && starve) return 1;
      if (rrb) return last ? 0 : 1;
      return 0;
   endfunction

   task automatic model_cycle(
      input int d, input bit rrb,
      input logic r0, input logic w0, input logic [DAW-1:0] a0, input logic [DW-1:0] wd0,
      input logic r1, input logic w1, input logic [DAW-1:0] a1, input logic [DW-1:0] wd1,
      input logic lck,
      input logic ack0, input logic ack1, input logic [DW-1:0] rdt0, input logic [DW-1:0] rdt1,
      input logic ena, input logic wen, input logic [DAW-1:0] adr, input logic [DW-1:0] wdt);
      int w;
      bit ew;
      bit [DAW-1:0] ea;
      bit [DW-1:0]  ed;
      bit [DW-1:0]  e0;
      bit [DW-1:0]  e1;
      if (rst) begin
         m_last[d] = 1'b1; m_lock[d] = 1'b0; m_wait[d] = 0;
         m_pv[d] = 1'b0; m_pp[d] = 0; m_hold[d][0] = '0; m_hold[d][1] = '0;
      end
      w  = pick(r0, r1, m_lock[d], m_wait[d] >= STV, m_last[d], rrb);
      ew = (w == 0) ? w0 : (w == 1) ? w1 : 1'b0;
      ea = (w == 0) ? a0 : (w == 1) ? a1 : '0;
      ed = (w == 0) ? wd0 : (w == 1) ? wd1 : '0;
      e0 = (m_pv[d] && m_pp[d] == 0) ? m_pd[d] : m_hold[d][0];
      e1 = (m_pv[d] && m_pp[d] == 1) ? m_pd[d] : m_hold[d][1];
      chk("ack0",    d, 32'(ack0), 32'(w == 0));
      chk("ack1",    d, 32'(ack1), 32'(w == 1));
      chk("mem_ena", d, 32'(ena),  32'(w >= 0));
      chk("mem_wen", d, 32'(wen),  32'(ew));
      chk("mem_adr", d, 32'(adr),  32'(ea));
      chk("mem_wdt", d, 32'(wdt),  32'(ed));
      chk("rdt0",    d, 32'(rdt0), 32'(e0));
      chk("rdt1",    d, 32'(rdt1), 32'(e1));
      if (preload_en) ref_mem[d][preload_adr] = preload_dat;
      if (!rst) begin
         if (m_pv[d]) m_hold[d][m_pp[d]] = m_pd[d];
         m_pv[d] = (w >= 0) && !ew;
         m_pp[d] = (w == 1) ? 1 : 0;
         if (m_pv[d]) m_pd[d] = ref_mem[d][ea];
         if (w >= 0) m_last[d] = (w == 1);
         m_lock[d] = (w == 1) && lck;
         if (w == 1 || !r1) m_wait[d] = 0;
         else if (m_wait[d] < STV) m_wait[d]++;
      end
      if (w >= 0 && ew) ref_mem[d][ea] = ed;
   endtask

   always @(negedge clk) begin
      model_cycle(0, 1'b1,
         bus_rr.p0_req, bus_rr.p0_wen, bus_rr.p0_adr, bus_rr.p0_wdt,
         bus_rr.p1_req, bus_rr.p1_wen, bus_rr.p1_adr, bus_rr.p1_wdt, bus_rr.p1_lck,
         bus_rr.p0_ack, bus_rr.p1_ack, bus_rr.p0_rdt, bus_rr.p1_rdt,
         bus_rr.mem_ena, bus_rr.mem_wen, bus_rr.mem_adr, bus_rr.mem_wdt);
      model_cycle(1, 1'b0,
         bus_fp.p0_req, bus_fp.p0_wen, bus_fp.p0_adr, bus_fp.p0_wdt,
         bus_fp.p1_req, bus_fp.p1_wen, bus_fp.p1_adr, bus_fp.p1_wdt, bus_fp.p1_lck,
         bus_fp.p0_ack, bus_fp.p1_ack, bus_fp.p0_rdt, bus_fp.p1_rdt,
         bus_fp.mem_ena, bus_fp.mem_wen, bus_fp.mem_adr, bus_fp.mem_wdt);
   end

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #2;
   endtask

   task automatic drv(input int d, input int port, input logic req, input logic wen,
                      input logic [DAW-1:0] adr, input logic [DW-1:0] wdt);
      if (d == 0 && port == 0) begin
         bus_rr.p0_req = req; bus_rr.p0_wen = wen; bus_rr.p0_adr = adr; bus_rr.p0_wdt = wdt;
      end else if (d == 0) begin
         bus_rr.p1_req = req; bus_rr.p1_wen = wen; bus_rr.p1_adr = adr; bus_rr.p1_wdt = wdt;
      end else if (port == 0) begin
         bus_fp.p0_req = req; bus_fp.p0_wen = wen; bus_fp.p0_adr = adr; bus_fp.p0_wdt = wdt;
      end else begin
         bus_fp.p1_req = req; bus_fp.p1_wen = wen; bus_fp.p1_adr = adr; bus_fp.p1_wdt = wdt;
      end
   endtask

   task automatic idle_all();
      for (int d = 0; d < 2; d++)
         for (int p = 0; p < 2; p++)
            drv(d, p, 1'b0, 1'b0, '0, '0);
      bus_rr.p1_lck = 1'b0;
      bus_fp.p1_lck = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      bit             seq [$];
      logic [DAW-1:0] aseq [$];
      bit             exp_seq [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
      logic [DAW-1:0] exp_adr [6] = '{13'h200, 13'h300, 13'h201, 13'h301, 13'h202, 13'h302};
      bit             exp_lk  [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
      logic [DAW-1:0] a0;
      logic [DAW-1:0] a1;
      logic [DW-1:0]  d0;
      int             i0;
      int             i1;
      int             k;
      bit             got;

      idle_all();
      // reset with memory preload
      tick();
      preload_en = 1'b1; preload_adr = 13'h010; preload_dat = 8'h5A;
      tick();
      preload_adr = 13'h0AB; preload_dat = 8'hC3;
      tick();
      preload_en = 1'b0;
      settle();
      chk("reset_p0_rdt", 0, 32'(bus_rr.p0_rdt), 32'h0);
      chk("reset_mem_ena", 0, 32'(bus_rr.mem_ena), 32'h0);
      tick();
      rst = 1'b0;

      // p0 read of preloaded 0x010
      tick();
      drv(0, 0, 1'b1, 1'b0, 13'h010, '0);
      settle();
      chk("t1_p0_ack", 0, 32'(bus_rr.p0_ack), 32'h1);
      tick();
      drv(0, 0, 1'b0, 1'b0, '0, '0);
      settle();
      chk("t1_p0_rdt", 0, 32'(bus_rr.p0_rdt), 32'h5A);
      chk("t1_p1_rdt", 0, 32'(bus_rr.p1_rdt), 32'h00);
      tick();
      settle();
      chk("t1_p0_hold", 0, 32'(bus_rr.p0_rdt), 32'h5A);

      // p1 access so that port 0 is next in the rotation
      tick();
      drv(0, 1, 1'b1, 1'b0, 13'h010, '0);
      tick();
      drv(0, 1, 1'b0, 1'b0, '0, '0);

      // both ports request continuously: p0 writes, p1 reads
      i0 = 0; i1 = 0;
      for (int c = 0; c < 6; c++) begin
         tick();
         a0 = 13'h200 + DAW'(i0);
         a1 = 13'h300 + DAW'(i1);
         d0 = 8'h10 + DW'(i0);
         drv(0, 0, 1'b1, 1'b1, a0, d0);
         drv(0, 1, 1'b1, 1'b0, a1, '0);
         settle();
         seq.push_back(bus_rr.p1_ack);
         aseq.push_back(bus_rr.mem_adr);
         if (bus_rr.p0_ack) i0++;
         if (bus_rr.p1_ack) i1++;
      end
      tick();
      idle_all();
      for (int c = 0; c < 6; c++) begin
         chk("t2_alt_p1_ack", 0, 32'(seq[c]), 32'(exp_seq[c]));
         chk("t2_alt_adr", 0, 32'(aseq[c]), 32'(exp_adr[c]));
      end

      // p1 write then p0 read of the same address on the next cycle
      tick();
      drv(0, 1, 1'b1, 1'b1, 13'h100, 8'h33);
      settle();
      chk("t3_p1_ack", 0, 32'(bus_rr.p1_ack), 32'h1);
      tick();
      drv(0, 1, 1'b0, 1'b0, '0, '0);
      drv(0, 0, 1'b1, 1'b0, 13'h100, '0);
      settle();
      chk("t3_p0_ack", 0, 32'(bus_rr.p0_ack), 32'h1);
      tick();
      drv(0, 0, 1'b0, 1'b0, '0, '0);
      settle();
      chk("t3_p0_rdt", 0, 32'(bus_rr.p0_rdt), 32'h33);

      // fixed priority: p1 starves until its 9th waiting cycle, twice in a row
      for (int rep = 0; rep < 2; rep++) begin
         k = 0; got = 1'b0;
         while (!got && k < 20) begin
            tick();
            drv(1, 0, 1'b1, 1'b0, 13'h010, '0);
            drv(1, 1, 1'b1, 1'b0, 13'h020, '0);
            k++;
            settle();
            if (bus_fp.p1_ack) got = 1'b1;
         end
         chk("t4_p1_wait_cycles", 1, 32'(k), 32'd9);
      end
      tick();
      idle_all();

      // p1 lock: four back-to-back p1 reads while p0 keeps requesting
      seq.delete();
      i1 = 0;
      for (int c = 0; c < 5; c++) begin
         tick();
         drv(0, 0, 1'b1, 1'b0, 13'h010, '0);
         if (i1 < 4) begin
            a1 = 13'h040 + DAW'(i1);
            drv(0, 1, 1'b1, 1'b0, a1, '0);
            bus_rr.p1_lck = 1'b1;
         end else begin
            drv(0, 1, 1'b0, 1'b0, '0, '0);
            bus_rr.p1_lck = 1'b0;
         end
         settle();
         seq.push_back(bus_rr.p1_ack);
         if (bus_rr.p1_ack) i1++;
      end
      tick();
      idle_all();
      for (int c = 0; c < 5; c++)
         chk("t5_lock_p1_ack", 0, 32'(seq[c]), 32'(exp_lk[c]));

      // reset in the cycle after a p0 read issue discards the read
      tick();
      drv(0, 0, 1'b1, 1'b0, 13'h0AB, '0);
      settle();
      chk("t6_p0_ack", 0, 32'(bus_rr.p0_ack), 32'h1);
      tick();
      drv(0, 0, 1'b0, 1'b0, '0, '0);
      rst = 1'b1;
      settle();
      chk("t6_rdt_in_reset", 0, 32'(bus_rr.p0_rdt), 32'h00);
      tick();
      tick();
      rst = 1'b0;
      settle();
      chk("t6_rdt_after_reset", 0, 32'(bus_rr.p0_rdt), 32'h00);
      tick();
      drv(0, 0, 1'b1, 1'b0, 13'h010, '0);
      drv(0, 1, 1'b1, 1'b0, 13'h011, '0);
      settle();
      chk("t6_first_contest_p0", 0, 32'(bus_rr.p0_ack), 32'h1);
      chk("t6_first_contest_p1", 0, 32'(bus_rr.p1_ack), 32'h0);
      tick();
      idle_all();
      tick();
      tick();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
